// File: rtl/boot_rom_arbiter.sv
// ---------------------------------------------------------------------------
// boot_rom_arbiter
//   Shares one single-port synchronous boot ROM between N_MASTERS requesters.
//   Round-robin grant, one-cycle fixed response latency, and error responses
//   for writes, out-of-range offsets and any access while lock_i is high.
//
// Ports
//   clk_i, rst_ni        clock, async active-low reset
//   lock_i               when 1, new accesses get an error and the ROM stays off
//   req_i/we_i/addr_i    per-master request, write enable, byte offset
//   gnt_o                per-master grant (combinational, one-hot or zero)
//   r_valid_o/r_rdata_o/r_err_o  per-master response, one cycle after grant
//   rom_csn_o/rom_addr_o/rom_rdata_i  ROM macro pins (data valid 1 cycle later)
//   err_cnt_o            saturating count of error responses
// ---------------------------------------------------------------------------

// Per-master slice: request classification and response demux.
module boot_rom_arbiter_lane #(
    parameter int ROM_ADDR_WIDTH = 13,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                  we,
    input  logic [31:0]           addr,
    output logic                  bad,       // write or out-of-range
    input  logic                  rsp_vld,
    input  logic                  rsp_sel,   // this lane owns the response
    input  logic                  rsp_err,
    input  logic [DATA_WIDTH-1:0] rom_rdata,
    output logic                  r_valid,
    output logic                  r_err,
    output logic [DATA_WIDTH-1:0] r_rdata
);
    // Word access only: byte-lane bits are deliberately ignored.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    assign bad     = we | (addr[31:ROM_ADDR_WIDTH] != '0);
    assign r_valid = rsp_vld & rsp_sel;
    assign r_err   = r_valid & rsp_err;
    // Errored accesses never enabled the ROM, so its output is stale: force 0.
    assign r_rdata = (r_valid & ~rsp_err) ? rom_rdata : '0;
endmodule

module boot_rom_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int ROM_ADDR_WIDTH = 13,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  lock_i,
    input  logic [N_MASTERS-1:0]                  req_i,
    input  logic [N_MASTERS-1:0]                  we_i,
    input  logic [N_MASTERS-1:0][31:0]            addr_i,
    output logic [N_MASTERS-1:0]                  gnt_o,
    output logic [N_MASTERS-1:0]                  r_valid_o,
    output logic [N_MASTERS-1:0][DATA_WIDTH-1:0]  r_rdata_o,
    output logic [N_MASTERS-1:0]                  r_err_o,
    output logic                                  rom_csn_o,
    output logic [ROM_ADDR_WIDTH-3:0]             rom_addr_o,
    input  logic [DATA_WIDTH-1:0]                 rom_rdata_i,
    output logic [15:0]                           err_cnt_o
);
    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef struct packed {
        logic             vld;
        logic             err;
        logic [IDX_W-1:0] idx;
    } rsp_t;

    logic             ready_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] win_idx;
    logic             gnt_any;
    logic             acc_err;
    rsp_t             rsp_q;
    logic [15:0]      err_cnt_q;
    logic [N_MASTERS-1:0] lane_bad;

    // Round-robin search. Walking offsets from the far end down to 0 lets the
    // closest requester to rr_ptr overwrite any farther one.
    always_comb begin
        int cand;
        cand    = 0;
        win_idx = '0;
        gnt_any = 1'b0;
        if (ready_q) begin
            for (int k = N_MASTERS - 1; k >= 0; k--) begin
                cand = int'(rr_ptr_q) + k;
                if (cand >= N_MASTERS) cand = cand - N_MASTERS;
                if (req_i[cand]) begin
                    win_idx = cand[IDX_W-1:0];
                    gnt_any = 1'b1;
                end
            end
        end
    end

    assign gnt_o      = N_MASTERS'(gnt_any) << win_idx;
    assign acc_err    = lock_i | lane_bad[win_idx];
    assign rom_csn_o  = ~(gnt_any & ~acc_err);
    assign rom_addr_o = gnt_any ? addr_i[win_idx][ROM_ADDR_WIDTH-1:2] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q   <= 1'b0;
            rr_ptr_q  <= '0;
            rsp_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            ready_q   <= 1'b1;
            rsp_q.vld <= gnt_any;
            if (gnt_any) begin
                rsp_q.idx <= win_idx;
                rsp_q.err <= acc_err;
                rr_ptr_q  <= (win_idx == IDX_W'(N_MASTERS - 1)) ? '0 : win_idx + 1'b1;
                if (acc_err && (err_cnt_q != 16'hFFFF))
                    err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign err_cnt_o = err_cnt_q;

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_lane
        boot_rom_arbiter_lane #(
            .ROM_ADDR_WIDTH(ROM_ADDR_WIDTH),
            .DATA_WIDTH    (DATA_WIDTH)
        ) u_lane (
            .we        (we_i[i]),
            .addr      (addr_i[i]),
            .bad       (lane_bad[i]),
            .rsp_vld   (rsp_q.vld),
            .rsp_sel   (rsp_q.idx == IDX_W'(i)),
            .rsp_err   (rsp_q.err),
            .rom_rdata (rom_rdata_i),
            .r_valid   (r_valid_o[i]),
            .r_err     (r_err_o[i]),
            .r_rdata   (r_rdata_o[i])
        );
    end
endmodule

// File: tb/tb_boot_rom_arbiter.sv
module tb_boot_rom_arbiter;
    localparam int N     = 2;
    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int WA    = AW - 2;
    localparam int DEPTH = 1 << WA;

    logic                     clk_i = 1'b0;
    logic                     rst_ni = 1'b0;
    logic                     lock_i = 1'b0;
    logic [N-1:0]             req_i = '0;
    logic [N-1:0]             we_i = '0;
    logic [N-1:0][31:0]       addr_i = '0;
    logic [N-1:0]             gnt_o;
    logic [N-1:0]             r_valid_o;
    logic [N-1:0][DW-1:0]     r_rdata_o;
    logic [N-1:0]             r_err_o;
    logic                     rom_csn_o;
    logic [WA-1:0]            rom_addr_o;
    logic [DW-1:0]            rom_q = '0;
    logic [15:0]              err_cnt_o;

    logic [DW-1:0] mem [DEPTH];

    boot_rom_arbiter #(.N_MASTERS(N), .ROM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .lock_i(lock_i),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_err_o(r_err_o),
        .rom_csn_o(rom_csn_o), .rom_addr_o(rom_addr_o), .rom_rdata_i(rom_q),
        .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // ROM macro: synchronous read when enabled; junk otherwise so any leak shows.
    always @(posedge clk_i) begin
        if (!rom_csn_o) rom_q <= mem[rom_addr_o];
        else            rom_q <= $urandom();
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: which master owns the ROM this cycle and what it must
    // see one cycle later, from the arbitration rules directly.
    bit          ready_m = 0;
    int          rr_m = 0;
    bit          pend_v = 0;
    int          pend_idx = 0;
    bit          pend_err = 0;
    logic [31:0] pend_data = '0;
    int          errcnt_m = 0;

    always @(negedge clk_i) begin
        int           win;
        bit           e;
        bit           ev;
        logic [N-1:0] eg;
        if (!rst_ni) begin
            chk("m_rst_gnt", gnt_o, 0);
            chk("m_rst_csn", rom_csn_o, 1);
            chk("m_rst_addr", rom_addr_o, 0);
            chk("m_rst_valid", r_valid_o, 0);
            chk("m_rst_errcnt", err_cnt_o, 0);
            ready_m = 0; rr_m = 0; pend_v = 0; errcnt_m = 0;
        end else begin
            for (int l = 0; l < N; l++) begin
                ev = pend_v && (pend_idx == l);
                chk("m_r_valid", r_valid_o[l], ev);
                chk("m_r_err", r_err_o[l], ev && pend_err);
                chk("m_r_rdata", r_rdata_o[l], (ev && !pend_err) ? pend_data : 32'h0);
            end
            chk("m_err_cnt", err_cnt_o, errcnt_m);

            win = -1;
            if (ready_m)
                for (int k = 0; k < N; k++)
                    if (win < 0 && req_i[(rr_m + k) % N]) win = (rr_m + k) % N;
            eg = '0;
            e  = 0;
            if (win >= 0) begin
                eg[win] = 1'b1;
                e = we_i[win] || lock_i || ((addr_i[win] >> AW) != 0);
            end
            chk("m_gnt", gnt_o, eg);
            chk("m_csn", rom_csn_o, (win >= 0 && !e) ? 1'b0 : 1'b1);
            chk("m_rom_addr", rom_addr_o, (win >= 0) ? addr_i[win][AW-1:2] : '0);

            pend_v = (win >= 0);
            if (win >= 0) begin
                pend_idx  = win;
                pend_err  = e;
                pend_data = mem[addr_i[win][AW-1:2]];
                rr_m      = (win + 1) % N;
                if (e && errcnt_m < 65535) errcnt_m++;
            end
            ready_m = 1;
        end
    end

    task automatic step(input logic [N-1:0] rq, input logic [N-1:0] w,
                        input logic [31:0] a0, input logic [31:0] a1, input logic lk);
        @(posedge clk_i);
        #1;
        req_i = rq; we_i = w; addr_i[0] = a0; addr_i[1] = a1; lock_i = lk;
        @(negedge clk_i);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
        mem[11'h21] = 32'hDEADBEEF;

        // Reset release with both masters requesting
        req_i = 2'b11;
        repeat (3) begin
            @(negedge clk_i);
            chk("rst_gnt", gnt_o, 0);
            chk("rst_csn", rom_csn_o, 1);
        end
        @(posedge clk_i); #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("first_cycle_gnt", gnt_o, 0);
        chk("first_cycle_csn", rom_csn_o, 1);
        step(2'b11, 2'b00, 0, 0, 0); chk("rr_grant0", gnt_o, 2'b01);
        step(2'b11, 2'b00, 0, 0, 0); chk("rr_grant1", gnt_o, 2'b10);
        step(2'b11, 2'b00, 0, 0, 0); chk("rr_grant2", gnt_o, 2'b01);

        // Single read by master 1 (rr_ptr now 1)
        step(2'b10, 2'b00, 0, 32'h84, 0);
        chk("rd_gnt", gnt_o, 2'b10);
        chk("rd_csn", rom_csn_o, 0);
        chk("rd_addr", rom_addr_o, 11'h21);
        step(2'b00, 2'b00, 0, 0, 0);
        chk("rd_valid", r_valid_o, 2'b10);
        chk("rd_data", r_rdata_o[1], 32'hDEADBEEF);
        chk("rd_err", r_err_o, 0);

        // Back-to-back fairness, rr_ptr is 0 here
        for (int c = 0; c < 8; c++) begin
            step(2'b11, 2'b00, 32'h100 + 4 * (c >> 1), 32'h200 + 4 * (c >> 1), 0);
            chk("b2b_gnt", gnt_o, (c % 2) ? 2'b10 : 2'b01);
            if (c > 0) chk("b2b_valid", r_valid_o, ((c - 1) % 2) ? 2'b10 : 2'b01);
        end
        step(2'b00, 2'b00, 0, 0, 0);
        chk("b2b_last_valid", r_valid_o, 2'b10);

        // Error cases; lock drops during the locked access's response cycle
        step(2'b01, 2'b01, 32'h10, 0, 0);
        chk("err_wr_gnt", gnt_o, 2'b01); chk("err_wr_csn", rom_csn_o, 1);
        step(2'b01, 2'b00, 32'h2000, 0, 0);
        chk("err_wr_rsp", {r_valid_o[0], r_err_o[0], r_rdata_o[0]}, {2'b11, 32'h0});
        chk("err_oor_gnt", gnt_o, 2'b01); chk("err_oor_csn", rom_csn_o, 1);
        step(2'b01, 2'b00, 32'h10, 0, 1);
        chk("err_oor_rsp", {r_valid_o[0], r_err_o[0], r_rdata_o[0]}, {2'b11, 32'h0});
        chk("err_lock_gnt", gnt_o, 2'b01); chk("err_lock_csn", rom_csn_o, 1);
        step(2'b00, 2'b00, 0, 0, 0);
        chk("err_lock_rsp", {r_valid_o[0], r_err_o[0], r_rdata_o[0]}, {2'b11, 32'h0});
        chk("err_cnt3", err_cnt_o, 16'd3);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a [N];
            for (int m = 0; m < N; m++)
                a[m] = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 8191));
            step(N'($urandom()),
                 {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)},
                 a[0], a[1], ($urandom_range(0, 7) == 0));
        end

        // Reset in the response cycle of a master-0 grant (rr_ptr would be 1)
        step(2'b00, 2'b00, 0, 0, 0);
        step(2'b01, 2'b00, 32'h40, 0, 0);
        chk("mid_gnt", gnt_o, 2'b01);
        @(posedge clk_i);
        #1 chk("mid_valid_before", r_valid_o, 2'b01);
        #1 rst_ni = 1'b0; req_i = '0;
        #1 chk("mid_valid_drop", r_valid_o, 0);
        repeat (2) @(negedge clk_i);
        @(posedge clk_i); #1 rst_ni = 1'b1; req_i = 2'b11;
        @(negedge clk_i);
        chk("mid_no_rsp", r_valid_o, 0);
        chk("mid_errcnt_clr", err_cnt_o, 0);
        step(2'b11, 2'b00, 0, 0, 0);
        chk("mid_rr_reset", gnt_o, 2'b01);
        chk("mid_no_rsp2", r_valid_o, 0);

        // Error counter saturation
        step(2'b00, 2'b00, 0, 0, 0);
        repeat (65537) step(2'b01, 2'b01, 32'h10, 0, 0);
        step(2'b00, 2'b00, 0, 0, 0);
        chk("sat_cnt", err_cnt_o, 16'hFFFF);
        repeat (3) step(2'b01, 2'b01, 32'h10, 0, 0);
        step(2'b00, 2'b00, 0, 0, 0);
        chk("sat_hold", err_cnt_o, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
